traffic_phase_sequencer: RTL and testbench

- Sequences a 4-way intersection through GREEN -> YELLOW -> ALL_RED phases, one approach at a time.
- Grants the next green round-robin among approaches with a waiting vehicle.
- Drives the 2-bit select of the intersection's 4-to-1 mux: sel[1] -> S1, sel[0] -> S0. The mux picks the per-approach signal of the active approach.
- Also drives per-approach green/yellow/red lamp outputs.

---
 rtl/traffic_pkg.sv | 25 ++
 rtl/rr_next_approach.sv | 17 +
 rtl/traffic_phase_sequencer.sv | 100 ++++++++++
 tb/tb_traffic_phase_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the traffic phase sequencer
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_ALLRED  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  localparam logic [1:0] APP_N = 2'd0;
  localparam logic [1:0] APP_E = 2'd1;
  localparam logic [1:0] APP_S = 2'd2;
  localparam logic [1:0] APP_W = 2'd3;

  localparam int GREEN_T_DEF  = 20;
  localparam int YELLOW_T_DEF = 4;
  localparam int ALLRED_T_DEF = 2;
  localparam int TW_DEF       = 8;

  function automatic logic [3:0] onehot(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

endpackage

// File: rtl/rr_next_approach.sv
// rtl/rr_next_approach.sv - combinational 4-way round-robin picker of the next green approach
module rr_next_approach (
  input  logic [3:0] req,
  input  logic [1:0] cur,
  output logic [1:0] next
);

  // Lowest priority is assigned first so nearer approaches (cur+1 first) overwrite it.
  always_comb begin
    next = cur + 2'd1;
    if (req[cur]) next = cur;
    for (int k = 3; k >= 1; k--) begin
      if (req[cur + 2'(k)]) next = cur + 2'(k);
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - green/yellow/all-red sequencer for a 4-way intersection
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int YELLOW_T = YELLOW_T_DEF,
  parameter int ALLRED_T = ALLRED_T_DEF,
  parameter int TW       = TW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic       phase_start
);

  localparam logic [TW-1:0] G_LAST = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] A_LAST = TW'(ALLRED_T - 1);

  state_t        state, state_n;
  logic [1:0]    cur, cur_n, rr_next;
  logic [TW-1:0] timer, timer_n;
  logic          start_q, start_n;
  logic [3:0]    others;

  rr_next_approach u_rr (
    .req  (req),
    .cur  (cur),
    .next (rr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_GREEN;
      cur     <= APP_N;
      timer   <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      timer   <= timer_n;
      start_q <= start_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    timer_n = timer;
    start_n = 1'b0;
    others  = req & ~onehot(cur);
    case (state)
      ST_GREEN: begin
        // Timer saturates at G_LAST so a late request leaves green on the next edge.
        if (timer == G_LAST) begin
          if (others != 4'b0000) begin
            state_n = ST_YELLOW;
            timer_n = '0;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_YELLOW: begin
        if (timer == Y_LAST) begin
          state_n = ST_ALLRED;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_ALLRED: begin
        if (timer == A_LAST) begin
          state_n = ST_GREEN;
          timer_n = '0;
          cur_n   = rr_next;
          start_n = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        state_n = ST_GREEN;
        cur_n   = APP_N;
        timer_n = '0;
      end
    endcase
  end

  assign sel         = cur;
  assign green       = (state == ST_GREEN)  ? onehot(cur) : 4'b0000;
  assign yellow      = (state == ST_YELLOW) ? onehot(cur) : 4'b0000;
  assign red         = ~(green | yellow);
  assign phase_start = start_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb/tb_traffic_phase_sequencer.sv - scoreboard bench for traffic_phase_sequencer
module tb_traffic_phase_sequencer;

  localparam int GREEN_T  = 20;
  localparam int YELLOW_T = 4;
  localparam int ALLRED_T = 2;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;
    logic       ps;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [1:0] sel;
  logic [3:0] green, yellow, red;
  logic       phase_start;

  obs_t  sb[$];
  string tags[$];
  string tag = "reset";
  int    n_vec = 0;
  int    n_bad = 0;

  traffic_phase_sequencer #(
    .GREEN_T  (GREEN_T),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T),
    .TW       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .sel         (sel),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;

  function automatic obs_t eg(input logic [1:0] a, input logic ps);
    logic [3:0] oh;
    oh = 4'b0001 << a;
    return '{sel: a, green: oh, yellow: 4'b0000, red: ~oh, ps: ps};
  endfunction

  function automatic obs_t ey(input logic [1:0] a);
    logic [3:0] oh;
    oh = 4'b0001 << a;
    return '{sel: a, green: 4'b0000, yellow: oh, red: ~oh, ps: 1'b0};
  endfunction

  function automatic obs_t ea(input logic [1:0] a);
    return '{sel: a, green: 4'b0000, yellow: 4'b0000, red: 4'b1111, ps: 1'b0};
  endfunction

  // Drive inputs for one edge and queue the outputs expected right after it.
  task automatic cyc(input logic r, input logic [3:0] q, input obs_t e);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  // Rest of green on a (first green cycle already queued), yellow, all-red, first green of b.
  task automatic full_cycle(input logic [1:0] a, input logic [1:0] b, input logic [3:0] q);
    repeat (GREEN_T - 1)  cyc(1'b0, q, eg(a, 1'b0));
    repeat (YELLOW_T)     cyc(1'b0, q, ey(a));
    repeat (ALLRED_T)     cyc(1'b0, q, ea(a));
    cyc(1'b0, q, eg(b, 1'b1));
  endtask

  initial begin
    obs_t  e, act;
    string t;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        t   = tags.pop_front();
        act = '{sel: sel, green: green, yellow: yellow, red: red, ps: phase_start};
        n_vec++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s t=%0t: got sel=%b g=%b y=%b r=%b ps=%b, want sel=%b g=%b y=%b r=%b ps=%b",
                   t, $time, act.sel, act.green, act.yellow, act.red, act.ps,
                   e.sel, e.green, e.yellow, e.red, e.ps);
        end
      end
    end
  end

  initial begin
    tag = "reset_idle";
    repeat (3)   cyc(1'b1, 4'b0000, eg(2'd0, 1'b0));
    repeat (100) cyc(1'b0, 4'b0000, eg(2'd0, 1'b0));

    tag = "first_handoff";
    repeat (2) cyc(1'b1, 4'b0100, eg(2'd0, 1'b0));
    full_cycle(2'd0, 2'd2, 4'b0100);

    tag = "round_robin";
    full_cycle(2'd2, 2'd3, 4'b1011);
    full_cycle(2'd3, 2'd0, 4'b1011);
    full_cycle(2'd0, 2'd1, 4'b1011);
    full_cycle(2'd1, 2'd3, 4'b1011);

    tag = "saturated_timer";
    full_cycle(2'd3, 2'd0, 4'b1011);
    repeat (50)       cyc(1'b0, 4'b0000, eg(2'd0, 1'b0));
    repeat (YELLOW_T) cyc(1'b0, 4'b0010, ey(2'd0));
    repeat (ALLRED_T) cyc(1'b0, 4'b0010, ea(2'd0));
    cyc(1'b0, 4'b0010, eg(2'd1, 1'b1));

    tag = "withdrawn_fallback";
    repeat (GREEN_T - 1) cyc(1'b0, 4'b0100, eg(2'd1, 1'b0));
    repeat (YELLOW_T)    cyc(1'b0, 4'b0100, ey(2'd1));
    repeat (ALLRED_T)    cyc(1'b0, 4'b0100, ea(2'd1));
    cyc(1'b0, 4'b0000, eg(2'd2, 1'b1));

    tag = "reset_mid_yellow";
    repeat (GREEN_T - 1) cyc(1'b0, 4'b0001, eg(2'd2, 1'b0));
    repeat (2)           cyc(1'b0, 4'b0001, ey(2'd2));
    cyc(1'b1, 4'b0001, eg(2'd0, 1'b0));
    tag = "timer_restart";
    full_cycle(2'd0, 2'd1, 4'b0010);

    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
